// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder: strips E0/F0 prefixes, collapses Pause, flags device
// replies and queues {ext, break, code} key events in a small FIFO.
module ps2_scancode_decoder #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       key_rd,
  input  logic       clr_ovf,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       dev_ack,
  output logic       dev_bat,
  output logic       dev_err,
  output logic       overflow,
  output logic [2:0] dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rx_done_q;
  logic          ack_d, bat_d, err_d;
  logic          push_req;
  logic [9:0]    push_entry;
  logic          accept;

  logic [9:0]    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty, full, pop, do_push;

  assign accept = rx_done & ~rx_done_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    push_req   = 1'b0;
    push_entry = {2'b00, rx_data};
    ack_d      = 1'b0;
    bat_d      = 1'b0;
    err_d      = 1'b0;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          case (rx_data)
            8'hE0:               state_d = S_EXT;
            8'hF0:               state_d = S_BRK;
            8'hE1: begin         state_d = S_SKIP; cnt_d = 3'd7; end
            8'hFA:               ack_d = 1'b1;
            8'hAA:               bat_d = 1'b1;
            8'hFE, 8'h00, 8'hFF: err_d = 1'b1;
            default:             push_req = 1'b1;
          endcase
        end
        S_EXT: begin
          if (rx_data == 8'hF0) state_d = S_EXT_BRK;
          else if (rx_data != 8'hE0) begin
            push_req   = 1'b1;
            push_entry = {2'b10, rx_data};
            state_d    = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          // A second prefix after F0 is malformed: drop the sequence silently.
          state_d = S_IDLE;
          if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
            push_req   = 1'b1;
            push_entry = {(state_q == S_EXT_BRK), 1'b1, rx_data};
          end
        end
        S_SKIP: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            push_req   = 1'b1;
            push_entry = {2'b00, 8'hE1};
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && timer_q == TW'(TIMEOUT - 1)) begin
      state_d = S_IDLE;
    end
    timer_d = (accept || state_d == S_IDLE) ? '0 : timer_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      timer_q   <= '0;
      rx_done_q <= 1'b1;  // a byte already pending at reset release is not taken
      dev_ack   <= 1'b0;
      dev_bat   <= 1'b0;
      dev_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      rx_done_q <= rx_done;
      dev_ack   <= ack_d;
      dev_bat   <= bat_d;
      dev_err   <= err_d;
    end
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = key_rd & ~empty;
  assign do_push = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (clr_ovf)             overflow <= 1'b0;
    end
  end

  assign key_valid = ~empty;
  assign {key_ext, key_break, key_code} = empty ? 10'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: table of byte sequences plus hand-written corner
// sequences; expected key events go through a queue and are compared as they are popped.
module tb_ps2_scancode_decoder;

  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       key_rd;
  logic       clr_ovf;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       dev_ack;
  logic       dev_bat;
  logic       dev_err;
  logic       overflow;
  logic [2:0] dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [9:0] exp_q[$];

  ps2_scancode_decoder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .key_rd(key_rd),
    .clr_ovf(clr_ovf), .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .dev_ack(dev_ack), .dev_bat(dev_bat), .dev_err(dev_err),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // dev_* pulse monitor
  int   ack_cnt = 0, bat_cnt = 0, err_cnt = 0, wide_cnt = 0;
  logic prev_ack = 1'b0, prev_bat = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    if (dev_ack) ack_cnt++;
    if (dev_bat) bat_cnt++;
    if (dev_err) err_cnt++;
    if ((dev_ack && prev_ack) || (dev_bat && prev_bat) || (dev_err && prev_err)) wide_cnt++;
    prev_ack = dev_ack;
    prev_bat = dev_bat;
    prev_err = dev_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic rd, input logic clr);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    key_rd  = rd;
    clr_ovf = clr;
    @(negedge clk);
    rx_done = 1'b0;
    key_rd  = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drain(input string name);
    logic [9:0] e;
    int         w;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      w = 0;
      while (!key_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!key_valid) begin
        check({name, "_timeout"}, 32'(key_valid), 32'd1);
      end else begin
        check({name, "_entry"}, 32'({key_ext, key_break, key_code}), 32'(e));
        key_rd = 1'b1;
        @(negedge clk);
        key_rd = 1'b0;
      end
    end
    @(negedge clk);
    check({name, "_empty"}, 32'(key_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({key_valid, key_code, key_ext, key_break, dev_ack, dev_bat, dev_err,
                     overflow, dbg_state}), 32'd0);
  endtask

  typedef struct {
    int         n;
    logic [7:0] b [4];
    logic       has_ev;
    logic [9:0] ev;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int a0, b0, e0;

    vecs[0] = '{1, '{8'h1C, 8'h00, 8'h00, 8'h00}, 1'b1, 10'h01C};
    vecs[1] = '{2, '{8'hF0, 8'h1C, 8'h00, 8'h00}, 1'b1, 10'h11C};
    vecs[2] = '{2, '{8'hE0, 8'h75, 8'h00, 8'h00}, 1'b1, 10'h275};
    vecs[3] = '{3, '{8'hE0, 8'hF0, 8'h75, 8'h00}, 1'b1, 10'h375};
    vecs[4] = '{3, '{8'hE0, 8'hE0, 8'h6B, 8'h00}, 1'b1, 10'h26B};
    vecs[5] = '{2, '{8'hF0, 8'hE0, 8'h00, 8'h00}, 1'b0, 10'h000};
    vecs[6] = '{3, '{8'hE0, 8'hF0, 8'hF0, 8'h00}, 1'b0, 10'h000};
    vecs[7] = '{2, '{8'hE0, 8'hFA, 8'h00, 8'h00}, 1'b1, 10'h2FA};
    vecs[8] = '{2, '{8'hF0, 8'hAA, 8'h00, 8'h00}, 1'b1, 10'h1AA};
    vecs[9] = '{1, '{8'h5A, 8'h00, 8'h00, 8'h00}, 1'b1, 10'h05A};

    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; key_rd = 1'b0; clr_ovf = 1'b0;
    idle_cycles(3);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    idle_cycles(2);

    // table: prefix handling, dev_* must stay silent
    a0 = ack_cnt; b0 = bat_cnt; e0 = err_cnt;
    for (int v = 0; v < 10; v++) begin
      for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].b[k], 1'b0, 1'b0);
      if (vecs[v].has_ev) exp_q.push_back(vecs[v].ev);
      drain($sformatf("vec%0d", v));
    end
    check("table_no_dev_pulse", 32'((ack_cnt - a0) + (bat_cnt - b0) + (err_cnt - e0)), 32'd0);

    // E0 F0 then timeout, then a plain make
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0);
    idle_cycles(TIMEOUT + 5);
    send_byte(8'h1C, 1'b0, 1'b0);
    exp_q.push_back(10'h01C);
    drain("timeout_idle");

    // F0 with a gap just under the timeout still completes the break
    send_byte(8'hF0, 1'b0, 1'b0);
    idle_cycles(TIMEOUT - 10);
    send_byte(8'h1C, 1'b0, 1'b0);
    exp_q.push_back(10'h11C);
    drain("no_early_timeout");

    // Pause collapses to a single E1 entry
    send_byte(8'hE1, 1'b0, 1'b0); send_byte(8'h14, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b0); send_byte(8'hE1, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0); send_byte(8'h14, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0); send_byte(8'h77, 1'b0, 1'b0);
    exp_q.push_back(10'h0E1);
    drain("pause");

    // device replies in IDLE
    a0 = ack_cnt; b0 = bat_cnt; e0 = err_cnt;
    send_byte(8'hFA, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hFE, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    check("dev_ack_count", 32'(ack_cnt - a0), 32'd1);
    check("dev_bat_count", 32'(bat_cnt - b0), 32'd1);
    check("dev_err_count", 32'(err_cnt - e0), 32'd3);
    check("dev_pulse_width", 32'(wide_cnt), 32'd0);
    check("dev_fifo_empty", 32'(key_valid), 32'd0);

    // overflow: DEPTH+1 makes, then a drop together with clr_ovf
    for (int i = 0; i <= DEPTH; i++) begin
      send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
      if (i < DEPTH) exp_q.push_back(10'h010 + 10'(i));
    end
    check("overflow_set", 32'(overflow), 32'd1);
    send_byte(8'h40, 1'b0, 1'b1);
    check("overflow_set_wins", 32'(overflow), 32'd1);
    send_byte(8'h00, 1'b0, 1'b0);  // dev_err byte: no push
    @(negedge clk); clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
    check("overflow_cleared", 32'(overflow), 32'd0);
    // full FIFO, pop and push in the same edge
    check("full_pop_head", 32'({key_ext, key_break, key_code}), 32'(exp_q.pop_front()));
    send_byte(8'h30, 1'b1, 1'b0);
    exp_q.push_back(10'h030);
    check("full_push_pop_no_ovf", 32'(overflow), 32'd0);
    drain("full_push_pop");

    // rx_done held high yields one byte
    @(negedge clk); rx_data = 8'h1C; rx_done = 1'b1;
    idle_cycles(20);
    rx_done = 1'b0;
    exp_q.push_back(10'h01C);
    drain("held_rx_done");

    // reset after a break prefix
    send_byte(8'hF0, 1'b0, 1'b0);
    rst = 1'b1;
    idle_cycles(2);
    check_all_zero("mid_reset_outputs");
    rst = 1'b0;
    idle_cycles(2);
    send_byte(8'h1C, 1'b0, 1'b0);
    exp_q.push_back(10'h01C);
    drain("after_reset");

    // byte already pending when reset releases is not taken
    @(negedge clk); rx_data = 8'h22; rx_done = 1'b1; rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(4);
    rx_done = 1'b0;
    idle_cycles(2);
    check("pending_byte_ignored", 32'(key_valid), 32'd0);

    check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
